// File: rtl/mac_rx.sv
// mac_rx: receive-side Ethernet MAC framer.
// Strips preamble/SFD, checks length and CRC-32, hides the 4 FCS bytes behind
// a 4-byte delay line and stages each frame in a store-and-forward buffer.
// A frame only becomes visible to the reader once it is committed as good.
module mac_rx #(
    parameter int ADDR_WIDTH = 12,
    parameter int MIN_FRAME  = 64,
    parameter int MAX_FRAME  = 1518
) (
    input  logic       mac_rx_aclk,
    input  logic       mac_rx_aresetn,
    input  logic [7:0] mac_rx_tdata,
    input  logic       mac_rx_tvalid,
    input  logic       mac_rx_tlast,
    output logic [7:0] payload_rx_tdata,
    output logic       payload_rx_tvalid,
    output logic       payload_rx_tlast,
    input  logic       payload_rx_tready,
    output logic       stat_good,
    output logic       stat_crc_err,
    output logic       stat_len_err,
    output logic       stat_overflow,
    output logic       stat_framing_err
);

    localparam int          DEPTH       = 2**ADDR_WIDTH;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [10:0] MIN_L       = 11'(MIN_FRAME);
    localparam logic [10:0] MAX_L       = 11'(MAX_FRAME);

    localparam logic [1:0] CAUSE_FRAMING = 2'd0;
    localparam logic [1:0] CAUSE_LEN     = 2'd1;
    localparam logic [1:0] CAUSE_OVF     = 2'd2;

    typedef logic [ADDR_WIDTH:0] ptr_t;
    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    // CRC-32 (poly 04C11DB7), MSB-first register, data bits fed LSB first
    // as they appear on the wire; a good frame+FCS leaves C704DD7B.
    function automatic logic [31:0] next_crc(input logic [7:0] d, input logic [31:0] c);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    state_t          state_q;
    logic [31:0]     crc_q;
    logic [10:0]     cnt_q;
    logic [3:0][7:0] dly_q;
    logic [2:0]      dly_n_q;
    logic [1:0]      cause_q;
    ptr_t            wr_ptr_q, commit_ptr_q, rd_ptr_q;

    logic [8:0]      mem [DEPTH];
    logic [8:0]      ram_data_q;
    logic            ram_vld_q;
    logic [8:0]      out_q;
    logic            out_vld_q;

    logic [31:0]     crc_d;
    logic [10:0]     cnt_d;
    logic            dly_full, full, len_ok, len_over, wr_en;
    logic            out_ready, ram_ready, rd_en;

    // Per-beat helpers: next CRC/count, buffer occupancy, write enable
    always_comb begin
        crc_d    = next_crc(mac_rx_tdata, crc_q);
        cnt_d    = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
        dly_full = (dly_n_q == 3'd4);
        full     = ((wr_ptr_q - rd_ptr_q) == ptr_t'(DEPTH));
        len_ok   = (cnt_d >= MIN_L) && (cnt_d <= MAX_L);
        len_over = (cnt_d > MAX_L);
        wr_en    = (state_q == S_DATA) && mac_rx_tvalid && dly_full && !full;
    end

    // Receive FSM: framing, CRC/length checks, write pointer, commit, stat pulses
    always_ff @(posedge mac_rx_aclk or negedge mac_rx_aresetn) begin
        if (!mac_rx_aresetn) begin
            state_q          <= S_IDLE;
            crc_q            <= 32'hFFFFFFFF;
            cnt_q            <= '0;
            dly_q            <= '0;
            dly_n_q          <= '0;
            cause_q          <= CAUSE_FRAMING;
            wr_ptr_q         <= '0;
            commit_ptr_q     <= '0;
            stat_good        <= 1'b0;
            stat_crc_err     <= 1'b0;
            stat_len_err     <= 1'b0;
            stat_overflow    <= 1'b0;
            stat_framing_err <= 1'b0;
        end else begin
            stat_good        <= 1'b0;
            stat_crc_err     <= 1'b0;
            stat_len_err     <= 1'b0;
            stat_overflow    <= 1'b0;
            stat_framing_err <= 1'b0;
            if (mac_rx_tvalid) begin
                case (state_q)
                    S_IDLE: begin
                        if (mac_rx_tlast)               stat_framing_err <= 1'b1;
                        else if (mac_rx_tdata == 8'h55) state_q <= S_PREAMBLE;
                        else begin
                            cause_q <= CAUSE_FRAMING;
                            state_q <= S_DROP;
                        end
                    end
                    S_PREAMBLE: begin
                        if (mac_rx_tlast) begin
                            stat_framing_err <= 1'b1;
                            state_q          <= S_IDLE;
                        end else if (mac_rx_tdata == 8'hD5) begin
                            crc_q   <= 32'hFFFFFFFF;
                            cnt_q   <= '0;
                            dly_n_q <= '0;
                            state_q <= S_DATA;
                        end else if (mac_rx_tdata != 8'h55) begin
                            cause_q <= CAUSE_FRAMING;
                            state_q <= S_DROP;
                        end
                    end
                    S_DATA: begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        dly_q <= {dly_q[2:0], mac_rx_tdata};
                        if (!dly_full) dly_n_q <= dly_n_q + 3'd1;
                        if (wr_en)     wr_ptr_q <= wr_ptr_q + ptr_t'(1);
                        if (mac_rx_tlast) begin
                            state_q <= S_IDLE;
                            if (wr_en && len_ok && crc_d == CRC_RESIDUE) begin
                                commit_ptr_q <= wr_ptr_q + ptr_t'(1);
                                stat_good    <= 1'b1;
                            end else begin
                                wr_ptr_q <= commit_ptr_q;
                                if (!len_ok)    stat_len_err  <= 1'b1;
                                else if (!wr_en) stat_overflow <= 1'b1;
                                else            stat_crc_err  <= 1'b1;
                            end
                        end else if (len_over) begin
                            cause_q <= CAUSE_LEN;
                            state_q <= S_DROP;
                        end else if (dly_full && full) begin
                            cause_q <= CAUSE_OVF;
                            state_q <= S_DROP;
                        end
                    end
                    default: begin // S_DROP
                        if (mac_rx_tlast) begin
                            wr_ptr_q <= commit_ptr_q;
                            state_q  <= S_IDLE;
                            case (cause_q)
                                CAUSE_LEN: stat_len_err     <= 1'b1;
                                CAUSE_OVF: stat_overflow    <= 1'b1;
                                default:   stat_framing_err <= 1'b1;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    // Read side may advance when downstream stages have room
    always_comb begin
        out_ready = !out_vld_q || payload_rx_tready;
        ram_ready = !ram_vld_q || out_ready;
        rd_en     = (rd_ptr_q != commit_ptr_q) && ram_ready;
    end

    // Frame buffer: write from the delay line, registered read
    always_ff @(posedge mac_rx_aclk) begin
        if (wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= {mac_rx_tlast, dly_q[3]};
        if (rd_en) ram_data_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end

    // Read pointer, RAM-stage valid and AXIS output register
    always_ff @(posedge mac_rx_aclk or negedge mac_rx_aresetn) begin
        if (!mac_rx_aresetn) begin
            rd_ptr_q  <= '0;
            ram_vld_q <= 1'b0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (rd_en)     rd_ptr_q  <= rd_ptr_q + ptr_t'(1);
            if (ram_ready) ram_vld_q <= rd_en;
            if (out_ready) begin
                out_vld_q <= ram_vld_q;
                if (ram_vld_q) out_q <= ram_data_q;
            end
        end
    end

    assign payload_rx_tdata  = out_q[7:0];
    assign payload_rx_tlast  = out_q[8] & out_vld_q;
    assign payload_rx_tvalid = out_vld_q;

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: directed bench for mac_rx. A 4 KiB-buffer instance carries most
// tests; a 256-entry instance sees the same wire stream for the overflow case.
module tb_mac_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0, rx_last = 1'b0;

    logic [7:0] a_data, b_data;
    logic       a_valid, a_last, a_ready = 1'b1;
    logic       b_valid, b_last, b_ready = 1'b1;
    logic [4:0] a_st, b_st; // {good, crc, len, ovf, framing}

    always #5 clk = ~clk;

    mac_rx #(.ADDR_WIDTH(12)) dut (
        .mac_rx_aclk(clk), .mac_rx_aresetn(rst_n),
        .mac_rx_tdata(rx_data), .mac_rx_tvalid(rx_valid), .mac_rx_tlast(rx_last),
        .payload_rx_tdata(a_data), .payload_rx_tvalid(a_valid),
        .payload_rx_tlast(a_last), .payload_rx_tready(a_ready),
        .stat_good(a_st[4]), .stat_crc_err(a_st[3]), .stat_len_err(a_st[2]),
        .stat_overflow(a_st[1]), .stat_framing_err(a_st[0])
    );

    mac_rx #(.ADDR_WIDTH(8)) dut_s (
        .mac_rx_aclk(clk), .mac_rx_aresetn(rst_n),
        .mac_rx_tdata(rx_data), .mac_rx_tvalid(rx_valid), .mac_rx_tlast(rx_last),
        .payload_rx_tdata(b_data), .payload_rx_tvalid(b_valid),
        .payload_rx_tlast(b_last), .payload_rx_tready(b_ready),
        .stat_good(b_st[4]), .stat_crc_err(b_st[3]), .stat_len_err(b_st[2]),
        .stat_overflow(b_st[1]), .stat_framing_err(b_st[0])
    );

    int n_chk = 0, n_err = 0;
    logic [8:0] qa[$], qb[$], ea[$], eb[$];
    logic [7:0] wire_q[$];
    int cnt_a[5] = '{0, 0, 0, 0, 0}, cnt_b[5] = '{0, 0, 0, 0, 0};
    int sa[5] = '{0, 0, 0, 0, 0}, sb[5] = '{0, 0, 0, 0, 0};
    int stab_err = 0;
    logic stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0] prev_a = '0, prev_b = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, stat pulse counters and AXIS hold-while-stalled watch
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a <= 1'b0;
            stall_b <= 1'b0;
        end else begin
            if (a_valid && a_ready) qa.push_back({a_last, a_data});
            if (b_valid && b_ready) qb.push_back({b_last, b_data});
            if (stall_a && !(a_valid && {a_last, a_data} == prev_a)) stab_err <= stab_err + 1;
            if (stall_b && !(b_valid && {b_last, b_data} == prev_b)) stab_err <= stab_err + 1;
            stall_a <= a_valid && !a_ready;
            stall_b <= b_valid && !b_ready;
            prev_a  <= {a_last, a_data};
            prev_b  <= {b_last, b_data};
            for (int i = 0; i < 5; i++) begin
                if (a_st[4-i]) cnt_a[i] <= cnt_a[i] + 1;
                if (b_st[4-i]) cnt_b[i] <= cnt_b[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        repeat (n) tick();
    endtask

    // Wire frame: 7x55, D5, payload (seed+i), FCS (reflected CRC-32, LSB first)
    task automatic build(input int len, input int seed, input logic [7:0] fcs_xor,
                         input bit exp_a, input bit exp_b);
        logic [31:0] c;
        logic [7:0]  b;
        wire_q.delete();
        repeat (7) wire_q.push_back(8'h55);
        wire_q.push_back(8'hD5);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            b = 8'(seed + i);
            wire_q.push_back(b);
            if (exp_a) ea.push_back({i == len - 1, b});
            if (exp_b) eb.push_back({i == len - 1, b});
            c = c ^ {24'h0, b};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        wire_q.push_back(c[7:0] ^ fcs_xor);
        wire_q.push_back(c[15:8]);
        wire_q.push_back(c[23:16]);
        wire_q.push_back(c[31:24]);
    endtask

    // Send first n bytes of wire_q (all if n<0); tlast on the final one if with_last
    task automatic send(input int n, input bit with_last);
        int m;
        m = (n < 0) ? wire_q.size() : n;
        for (int i = 0; i < m; i++) begin
            rx_valid = 1'b1;
            rx_data  = wire_q[i];
            rx_last  = with_last && (i == m - 1);
            tick();
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    function automatic int qdiff(input logic [8:0] got[$], input logic [8:0] exp[$]);
        int m, n;
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        m = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
        for (int i = 0; i < n; i++) if (got[i] !== exp[i]) m++;
        return m;
    endfunction

    task automatic compare(input string tag, input bit use_b, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!use_b && qa.size() >= ea.size()) break;
            if (use_b && qb.size() >= eb.size()) break;
            tick();
        end
        repeat (6) tick();
        if (!use_b) begin
            chk({tag, " bytes"}, qa.size(), ea.size());
            chk({tag, " data"}, qdiff(qa, ea), 0);
            qa.delete(); ea.delete();
        end else begin
            chk({tag, " bytes"}, qb.size(), eb.size());
            chk({tag, " data"}, qdiff(qb, eb), 0);
            qb.delete(); eb.delete();
        end
    endtask

    // Stat pulse deltas since last call, packed {good,crc,len,ovf,framing}
    task automatic stat_chk(input string tag, input bit use_b,
                            input int g, input int c, input int l, input int o, input int f);
        logic [19:0] got, exp;
        exp = {4'(g), 4'(c), 4'(l), 4'(o), 4'(f)};
        if (!use_b) begin
            got = {4'(cnt_a[0]-sa[0]), 4'(cnt_a[1]-sa[1]), 4'(cnt_a[2]-sa[2]),
                   4'(cnt_a[3]-sa[3]), 4'(cnt_a[4]-sa[4])};
            sa = cnt_a;
        end else begin
            got = {4'(cnt_b[0]-sb[0]), 4'(cnt_b[1]-sb[1]), 4'(cnt_b[2]-sb[2]),
                   4'(cnt_b[3]-sb[3]), 4'(cnt_b[4]-sb[4])};
            sb = cnt_b;
        end
        chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset outputs", 32'({a_data, a_valid, a_last, a_st}), 32'h0);
        rst_n = 1'b1;
        idle(3);

        // 1) minimum-size good frame
        build(60, 0, 8'h00, 1, 0);
        send(-1, 1);
        compare("t1 good64", 0, 200);
        stat_chk("t1 stats", 0, 1, 0, 0, 0, 0);

        // 2) FCS corrupted, then a good frame
        build(60, 0, 8'h01, 0, 0);
        send(-1, 1);
        compare("t2 crc drop", 0, 20);
        stat_chk("t2 stats", 0, 0, 1, 0, 0, 0);
        build(60, 5, 8'h00, 1, 0);
        send(-1, 1);
        compare("t2 recover", 0, 200);
        stat_chk("t2 recover stats", 0, 1, 0, 0, 0, 0);

        // 3) runt and oversize frames
        build(36, 1, 8'h00, 0, 0);
        send(-1, 1);
        idle(3);
        stat_chk("t3 runt", 0, 0, 0, 1, 0, 0);
        build(1515, 2, 8'h00, 0, 0);
        send(-1, 1);
        compare("t3 no output", 0, 20);
        stat_chk("t3 oversize", 0, 0, 0, 1, 0, 0);

        // 4) back-pressure with three frames; small buffer overflows on frame 3
        qb.delete(); eb.delete();
        a_ready = 1'b0;
        b_ready = 1'b0;
        idle(4);
        sb = cnt_b;
        for (int k = 1; k <= 3; k++) begin
            build(100, 17 * k, 8'h00, 1, k < 3);
            send(-1, 1);
            idle(12);
        end
        chk("t4 nothing accepted", qa.size() + qb.size(), 0);
        stat_chk("t4 stats", 0, 3, 0, 0, 0, 0);
        stat_chk("t4 small stats", 1, 2, 0, 0, 1, 0);
        a_ready = 1'b1;
        b_ready = 1'b1;
        compare("t4 drain", 0, 400);
        compare("t4 small drain", 1, 400);

        // 5) framing errors
        wire_q = '{8'h55, 8'h55, 8'h12, 8'hAA, 8'hBB};
        send(-1, 1);
        idle(3);
        stat_chk("t5 bad sfd", 0, 0, 0, 0, 0, 1);
        wire_q = '{8'h55, 8'h55};
        send(-1, 1);
        idle(3);
        stat_chk("t5 early tlast", 0, 0, 0, 0, 0, 1);
        wire_q = '{8'h12, 8'h34};
        send(-1, 1);
        compare("t5 no output", 0, 10);
        stat_chk("t5 bad first byte", 0, 0, 0, 0, 0, 1);
        build(64, 40, 8'h00, 1, 0);
        send(-1, 1);
        compare("t5 recover", 0, 200);

        // 6) reset mid-DATA with a stalled output
        a_ready = 1'b0;
        b_ready = 1'b0;
        build(60, 9, 8'h00, 0, 0);
        send(-1, 1);
        for (int i = 0; i < 20 && !a_valid; i++) tick();
        chk("t6 stalled valid", a_valid, 1'b1);
        build(60, 11, 8'h00, 0, 0);
        send(30, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 reset outputs", 32'({a_data, a_valid, a_last, a_st, b_valid, b_st}), 32'h0);
        qa.delete(); qb.delete(); ea.delete(); eb.delete();
        #2 rst_n = 1'b1;
        idle(3);
        sa = cnt_a;
        a_ready = 1'b1;
        b_ready = 1'b1;
        build(80, 60, 8'h00, 1, 0);
        send(-1, 1);
        compare("t6 after reset", 0, 200);
        stat_chk("t6 stats", 0, 1, 0, 0, 0, 0);

        chk("axis hold while stalled", stab_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
